pipe_ctrl: RTL and testbench

Central pipeline sequencing controller for the 5-stage core. It combines the hazard unit's Stall, the ID-stage branch decision and the multi-cycle SRAM handshake of the MEM stage. From these it drives per-stage register enables and flushes, and it owns the SRAM request/ready protocol. It also keeps saturating performance counters for stall, freeze and flush cycles, plus a sticky memory-timeout error flag.

---
 rtl/pipe_ctrl.sv | 93 +++++++++
 tb/tb_pipe_ctrl.sv | 121 ++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline enable/flush sequencing with SRAM handshake, perf counters and timeout flag
module pipe_ctrl #(
   parameter int MEM_TIMEOUT = 64,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             Hazard_Stall,
   input  logic             Br_Taken,
   input  logic             Mem_R_En,
   input  logic             Mem_W_En,
   input  logic             SRAM_Ready,
   output logic             SRAM_Req,
   output logic             PC_En,
   output logic             IF_ID_En,
   output logic             IF_ID_Flush,
   output logic             ID_EXE_En,
   output logic             ID_EXE_Flush,
   output logic             EXE_MEM_En,
   output logic             MEM_WB_En,
   output logic             Freeze,
   output logic             Mem_Error,
   output logic [CNT_W-1:0] Stall_Cnt,
   output logic [CNT_W-1:0] Freeze_Cnt,
   output logic [CNT_W-1:0] Flush_Cnt
);
   localparam int WW = $clog2(MEM_TIMEOUT);
   typedef enum logic {S_RUN, S_WAIT} state_t;
   state_t state, state_nx;
   logic [WW-1:0] wait_cnt, wait_nx;
   logic mem_op, timeout, err_set, stall;
   assign mem_op = Mem_R_En | Mem_W_En;
   assign timeout = wait_cnt == WW'(MEM_TIMEOUT - 1);
   // state and wait counter; reset aborts any access in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_RUN;
         wait_cnt <= '0;
      end else begin
         state <= state_nx;
         wait_cnt <= wait_nx;
      end
   end
   // next state, request and freeze; timeout releases the pipeline like a Ready but drops the access
   always_comb begin
      state_nx = state;
      wait_nx = wait_cnt;
      err_set = 1'b0;
      Freeze = 1'b0;
      SRAM_Req = 1'b0;
      if (state == S_RUN) begin
         if (mem_op) begin
            Freeze = 1'b1;
            state_nx = S_WAIT;
            wait_nx = '0;
         end
      end else begin
         SRAM_Req = 1'b1;
         if (SRAM_Ready || timeout) begin
            state_nx = S_RUN;
            err_set = !SRAM_Ready;
         end else begin
            Freeze = 1'b1;
            wait_nx = wait_cnt + WW'(1);
         end
      end
   end
   // stage controls, priority Freeze > Hazard_Stall > Br_Taken
   always_comb begin
      stall = !Freeze && Hazard_Stall;
      PC_En = !Freeze && !Hazard_Stall;
      IF_ID_En = !Freeze && !Hazard_Stall;
      IF_ID_Flush = !Freeze && !Hazard_Stall && Br_Taken;
      ID_EXE_En = !Freeze;
      ID_EXE_Flush = stall;
      EXE_MEM_En = !Freeze;
      MEM_WB_En = !Freeze;
   end
   // sticky timeout flag and saturating performance counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         Mem_Error <= 1'b0;
         Stall_Cnt <= '0;
         Freeze_Cnt <= '0;
         Flush_Cnt <= '0;
      end else begin
         if (err_set) Mem_Error <= 1'b1;
         if (ID_EXE_Flush && !(&Stall_Cnt)) Stall_Cnt <= Stall_Cnt + CNT_W'(1);
         if (Freeze && !(&Freeze_Cnt)) Freeze_Cnt <= Freeze_Cnt + CNT_W'(1);
         if (IF_ID_Flush && !(&Flush_Cnt)) Flush_Cnt <= Flush_Cnt + CNT_W'(1);
      end
   end
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: scoreboard bench for pipe_ctrl against a transaction-level reference model
module tb_pipe_ctrl;
   localparam int TO = 4;
   localparam int CW = 5;
   localparam int MAXC = (1 << CW) - 1;
   logic clk = 0, rst_n = 0;
   logic hs = 0, br = 0, rd = 0, wr = 0, rdy = 0;
   logic req, pc_en, ifid_en, ifid_fl, idexe_en, idexe_fl, exmem_en, memwb_en, frz, merr;
   logic [CW-1:0] stall_cnt, frz_cnt, fl_cnt;
   typedef struct packed {
      logic [9:0] ctrl;
      logic [3*CW-1:0] cnt;
   } exp_t;
   exp_t exp_q[$];
   int checks = 0, errors = 0, cyc = 0;
   bit m_busy = 0, m_err = 0;
   int m_age = 0, m_sc = 0, m_fc = 0, m_flc = 0;

   pipe_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .Hazard_Stall(hs), .Br_Taken(br), .Mem_R_En(rd), .Mem_W_En(wr),
      .SRAM_Ready(rdy), .SRAM_Req(req), .PC_En(pc_en), .IF_ID_En(ifid_en), .IF_ID_Flush(ifid_fl),
      .ID_EXE_En(idexe_en), .ID_EXE_Flush(idexe_fl), .EXE_MEM_En(exmem_en), .MEM_WB_En(memwb_en),
      .Freeze(frz), .Mem_Error(merr), .Stall_Cnt(stall_cnt), .Freeze_Cnt(frz_cnt), .Flush_Cnt(fl_cnt)
   );

   always #5 clk = ~clk;

   function automatic int sat(int v);
      return v > MAXC ? MAXC : v;
   endfunction

   task automatic check(string name, logic [63:0] act, logic [63:0] req_v);
      checks++;
      if (act !== req_v) begin
         errors++;
         $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, req_v);
      end
   endtask

   // One clock of stimulus: the model predicts this cycle's outputs, then advances its own view of the access
   task automatic cycle(bit h, bit b, bit r, bit w, bit y);
      bit f, done, st, fl;
      exp_t e;
      @(posedge clk);
      #1;
      hs = h; br = b; rd = r; wr = w; rdy = y;
      done = m_busy && (y || m_age + 1 == TO);
      f = m_busy ? !done : (r || w);
      st = !f && h;
      fl = !f && !h && b;
      e.ctrl = {m_busy, !f && !h, !f && !h, fl, !f, st, !f, !f, f, m_err};
      e.cnt = {CW'(m_sc), CW'(m_fc), CW'(m_flc)};
      exp_q.push_back(e);
      m_sc = sat(m_sc + int'(st));
      m_fc = sat(m_fc + int'(f));
      m_flc = sat(m_flc + int'(fl));
      if (!m_busy) begin
         if (r || w) begin m_busy = 1; m_age = 0; end
      end else if (done) begin
         m_busy = 0;
         if (!y) m_err = 1;
      end else m_age++;
   endtask

   // Asynchronous reset pulse placed between clock edges, checked before the next edge arrives
   task automatic reset_pulse();
      @(negedge clk);
      #1 rst_n = 0;
      #1 check("async_reset", {req, merr, stall_cnt, frz_cnt, fl_cnt}, '0);
      hs = 0; br = 0; rd = 0; wr = 0; rdy = 0;
      @(negedge clk);
      #1 rst_n = 1;
      m_busy = 0; m_err = 0; m_age = 0; m_sc = 0; m_fc = 0; m_flc = 0;
   endtask

   // monitor: every presented cycle is popped and compared against the scoreboard entry
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         cyc++;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("ctrl", 64'({req, pc_en, ifid_en, ifid_fl, idexe_en, idexe_fl, exmem_en, memwb_en, frz, merr}), 64'(e.ctrl));
            check("counters", 64'({stall_cnt, frz_cnt, fl_cnt}), 64'(e.cnt));
         end
      end
   end

   initial begin
      #22 rst_n = 1;
      repeat (10) cycle(0, 0, 0, 0, 0);
      cycle(0, 0, 1, 0, 0); cycle(0, 0, 1, 0, 0); cycle(0, 0, 1, 0, 0); cycle(0, 0, 1, 0, 1);
      cycle(0, 0, 0, 0, 0);
      cycle(0, 0, 1, 0, 0); cycle(0, 0, 1, 0, 1); cycle(0, 0, 0, 1, 0); cycle(0, 0, 0, 1, 1);
      cycle(0, 0, 0, 0, 0);
      cycle(1, 1, 0, 0, 0); cycle(0, 1, 0, 0, 0); cycle(0, 0, 0, 0, 0);
      cycle(1, 0, 1, 0, 0); cycle(1, 0, 1, 0, 0); cycle(1, 1, 1, 0, 0); cycle(1, 0, 1, 0, 1);
      cycle(0, 0, 0, 0, 0);
      repeat (TO + 1) cycle(0, 0, 1, 0, 0);
      repeat (3) cycle(0, 0, 0, 0, 0);
      cycle(0, 0, 1, 0, 0); cycle(0, 0, 1, 0, 0);
      reset_pulse();
      repeat (3) cycle(0, 0, 0, 0, 0);
      repeat (40) cycle(1, 0, 0, 0, 0);
      repeat (40) cycle(0, 1, 0, 0, 0);
      for (int i = 0; i < 600; i++) begin
         if (i == 300) reset_pulse();
         cycle($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
               $urandom_range(0, 6) == 0, $urandom_range(0, 3) == 0);
      end
      repeat (4) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
